gpmc_sync_master: RTL and testbench

- FPGA-side initiator for the synchronous, multiplexed address/data GPMC bus.
- Turns single-word host requests into GPMC cycles on csn1/advn/wein/oen/ad and generates gpmc_clk from clk.
- Used to drive GPMC-attached slave logic from on-chip logic, for board loopback and for self-test.
- Top level instantiates the pad tristate (SB_IO) from the split ad_out/ad_oe/ad_in ports.

---
 rtl/gpmc_sync_master.sv | 151 +++++++++++++++
 tb/tb_gpmc_sync_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpmc_sync_master.sv
// GPMC synchronous muxed-AD bus initiator: single-word host requests to bus cycles.
// Define GPMC_CLK_GATE_EN to stop gpmc_clk whenever the master is idle.
module gpmc_sync_master #(
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 16,
  parameter int HALF_PERIOD = 2,
  parameter int DATA_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  gpmc_clk,
  output logic                  gpmc_csn1,
  output logic                  gpmc_advn,
  output logic                  gpmc_wein,
  output logic                  gpmc_oen,
  output logic [15:0]           gpmc_ad_out,
  output logic                  gpmc_ad_oe,
  input  logic [15:0]           gpmc_ad_in
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int PW = $clog2(DATA_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT, ADDR, DATA, RECOVER
  } state_t;

  state_t                state;
  logic [CW-1:0]         div;
  logic [PW-1:0]         per;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  wrap;
  logic                  rise;
  logic                  fall;
  logic                  last;

  assign wrap = div == CW'(HALF_PERIOD - 1);
  assign rise = wrap & ~gpmc_clk;
  assign fall = wrap & gpmc_clk;
  assign last = per == PW'(DATA_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div      <= '0;
      gpmc_clk <= 1'b0;
    end
`ifdef GPMC_CLK_GATE_EN
    // parked low while idle; the final rise that ends RECOVER is swallowed
    else if (state == IDLE || (state == RECOVER && rise)) begin
      div      <= '0;
      gpmc_clk <= 1'b0;
    end
`endif
    else if (wrap) begin
      div      <= '0;
      gpmc_clk <= ~gpmc_clk;
    end else begin
      div <= div + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      per         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      rdata       <= '0;
      gpmc_csn1   <= 1'b1;
      gpmc_advn   <= 1'b1;
      gpmc_wein   <= 1'b1;
      gpmc_oen    <= 1'b1;
      gpmc_ad_out <= '0;
      gpmc_ad_oe  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            ready   <= 1'b0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (rise) begin
            state       <= ADDR;
            gpmc_csn1   <= 1'b0;
            gpmc_advn   <= 1'b0;
            gpmc_ad_oe  <= 1'b1;
            gpmc_ad_out <= 16'(addr_q);
          end
        end
        ADDR: begin
          if (rise) begin
            state     <= DATA;
            per       <= '0;
            gpmc_advn <= 1'b1;
            if (we_q) begin
              gpmc_wein   <= 1'b0;
              gpmc_ad_out <= 16'(wdata_q);
            end else begin
              gpmc_oen    <= 1'b0;
              gpmc_ad_oe  <= 1'b0;
              gpmc_ad_out <= '0;
            end
          end
        end
        DATA: begin
          if (fall && last && !we_q)
            rdata <= DATA_WIDTH'(gpmc_ad_in);
          if (rise) begin
            if (last) begin
              state       <= RECOVER;
              gpmc_csn1   <= 1'b1;
              gpmc_wein   <= 1'b1;
              gpmc_oen    <= 1'b1;
              gpmc_ad_oe  <= 1'b0;
              gpmc_ad_out <= '0;
            end else begin
              per <= per + PW'(1);
            end
          end
        end
        RECOVER: begin
          if (rise) begin
            state <= IDLE;
            done  <= 1'b1;
            ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpmc_sync_master.sv
// Scoreboard bench for gpmc_sync_master: directed transactions checked by a bus monitor.
// Build with GPMC_CLK_GATE_EN to check the gated-clock variant.
module tb_gpmc_sync_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        ready;
  logic        done;
  logic [15:0] rdata;
  logic        gpmc_clk;
  logic        gpmc_csn1;
  logic        gpmc_advn;
  logic        gpmc_wein;
  logic        gpmc_oen;
  logic [15:0] gpmc_ad_out;
  logic        gpmc_ad_oe;
  logic [15:0] gpmc_ad_in;
  logic [15:0] slave_data = 16'h1234;

  always #5 clk = ~clk;

  // slave drives the pads only while the master enables its output
  assign gpmc_ad_in = !gpmc_oen ? slave_data : 16'h0000;

  gpmc_sync_master #(
    .ADDR_WIDTH(5), .DATA_WIDTH(16), .HALF_PERIOD(2), .DATA_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
    .gpmc_clk(gpmc_clk), .gpmc_csn1(gpmc_csn1), .gpmc_advn(gpmc_advn),
    .gpmc_wein(gpmc_wein), .gpmc_oen(gpmc_oen),
    .gpmc_ad_out(gpmc_ad_out), .gpmc_ad_oe(gpmc_ad_oe),
    .gpmc_ad_in(gpmc_ad_in)
  );

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wd;
    logic [15:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_total = 0;
  int proto = 0;
  int csn_n, adv_n, wr_n, rd_n, bad, adv_t, acc_t;
  logic prev_advn = 1'b1;
  logic prev_ready = 1'b1;
  logic [15:0] last_rd = 16'h0000;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_trans();
    csn_n = 0; adv_n = 0; wr_n = 0; rd_n = 0; bad = 0;
  endtask

  initial clear_trans();

  // monitor: samples at negedge, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      clear_trans();
      prev_advn  = 1'b1;
      prev_ready = 1'b1;
    end else begin
      if (!gpmc_advn && !gpmc_wein) proto++;
      if (!gpmc_wein && !gpmc_oen) proto++;
      if (gpmc_csn1 && !(gpmc_advn && gpmc_wein && gpmc_oen)) proto++;
      if (prev_ready && !ready) acc_t = cyc;
      if (prev_advn && !gpmc_advn) begin
        adv_t = cyc;
        if (gpmc_clk !== 1'b1) bad++;
`ifdef GPMC_CLK_GATE_EN
        check("wait_len", cyc - acc_t, 2);
`else
        check("wait_len_in_range",
              (cyc - acc_t >= 1 && cyc - acc_t <= 4) ? 1 : 0, 1);
`endif
      end
      if (!gpmc_csn1) csn_n++;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (!gpmc_advn) begin
          adv_n++;
          if (gpmc_ad_out !== {11'b0, e.addr} || gpmc_ad_oe !== 1'b1) bad++;
        end
        if (!gpmc_wein) begin
          wr_n++;
          if (gpmc_ad_out !== e.wd || gpmc_ad_oe !== 1'b1) bad++;
        end
        if (!gpmc_oen) begin
          rd_n++;
          if (gpmc_ad_oe !== 1'b0) bad++;
        end
      end
      if (done) begin
        done_total++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 required no done");
        end else begin
          e = exp_q.pop_front();
          check("rdata", rdata, e.rd);
          check("addr_cycles", adv_n, 4);
          check("data_cycles", e.we ? wr_n : rd_n, 16);
          check("other_strobe", e.we ? rd_n : wr_n, 0);
          check("csn_cycles", csn_n, 20);
          check("latency", cyc - adv_t, 24);
          check("bus_values", bad, 0);
          check("ready_at_done", ready, 1);
`ifdef GPMC_CLK_GATE_EN
          check("gclk_at_done", gpmc_clk, 0);
`else
          check("gclk_at_done", gpmc_clk, 1);
`endif
        end
        clear_trans();
      end
      prev_advn  = gpmc_advn;
      prev_ready = ready;
    end
  end

  // called at a negedge; drives 2 time units later
  task automatic issue(input logic w, input logic [4:0] a,
                       input logic [15:0] d);
    exp_t e;
    int n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready=0 required 1");
    end
    #2;
    req = 1'b1; we = w; addr = a; wdata = d;
    if (!w) last_rd = slave_data;
    e.we = w; e.addr = a; e.wd = d; e.rd = last_rd;
    exp_q.push_back(e);
    @(negedge clk);
    #2 req = 1'b0;
  endtask

  task automatic wait_done();
    logic got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = done;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done required done");
    end
  endtask

  initial begin
    int tog;
    logic pc;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_csn1", gpmc_csn1, 1);
    check("rst_advn", gpmc_advn, 1);
    check("rst_wein", gpmc_wein, 1);
    check("rst_oen", gpmc_oen, 1);
    check("rst_ad_oe", gpmc_ad_oe, 0);
    check("rst_ad_out", gpmc_ad_out, 0);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    tog = 0;
    pc = gpmc_clk;
    repeat (8) begin
      @(negedge clk);
      if (gpmc_clk !== pc) tog++;
      pc = gpmc_clk;
    end
`ifdef GPMC_CLK_GATE_EN
    check("idle_gclk_toggles", tog, 0);
    check("idle_gclk_level", gpmc_clk, 0);
`else
    check("idle_gclk_toggles", tog, 4);
`endif

    issue(1'b1, 5'h0A, 16'hBEEF);
    wait_done();
    @(negedge clk);

    slave_data = 16'h1234;
    issue(1'b0, 5'h03, 16'h0000);
    wait_done();
    // accepted in the done cycle, followed by a request that must be ignored
    issue(1'b1, 5'h1F, 16'h0001);
    repeat (6) @(negedge clk);
    #2;
    req = 1'b1; we = 1'b1; addr = 5'h07; wdata = 16'hFFFF;
    @(negedge clk);
    #2 req = 1'b0;
    wait_done();
    check("rdata_after_write", rdata, 16'h1234);
    repeat (10) @(negedge clk);
`ifdef GPMC_CLK_GATE_EN
    check("gclk_stopped_after_done", gpmc_clk, 0);
`endif
    check("done_pulses", done_total, 3);

    slave_data = 16'hC3C5;
    issue(1'b0, 5'h15, 16'h0000);
    wait_done();

    issue(1'b1, 5'h07, 16'hAAAA);
    for (int n = 0; n < 100 && gpmc_wein; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    last_rd = 16'h0000;
    @(negedge clk);
    check("midrst_csn1", gpmc_csn1, 1);
    check("midrst_advn", gpmc_advn, 1);
    check("midrst_wein", gpmc_wein, 1);
    check("midrst_oen", gpmc_oen, 1);
    check("midrst_ad_oe", gpmc_ad_oe, 0);
    check("midrst_ready", ready, 1);
    check("midrst_done", done, 0);
    check("midrst_gclk", gpmc_clk, 0);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", done_total, 4);
    check("rdata_after_rst", rdata, 0);
    check("protocol", proto, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

endmodule
